// File: rtl/sarlock_pkg.sv
// Shared types and constants for the SARLock serial-key unlock unit.
package sarlock_pkg;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [7:0] DEFAULT_CORRECT_KEY = 8'h4D;
    localparam int         FLIP_CNT_W          = 16;

    // Bit-counter width that still works for a 1-bit key.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sarlock_key_cmp.sv
// Combinational SARLock comparator: flags a flip when the input slice hits a wrong key.
module sarlock_key_cmp #(
    parameter int KEY_W = 8
) (
    input  logic [KEY_W-1:0] key_reg,
    input  logic [KEY_W-1:0] cmp_in,
    input  logic [KEY_W-1:0] correct_key,
    output logic             match,
    output logic             mask,
    output logic             f
);

    // The correct key masks every match, so it never corrupts an output.
    always_comb begin
        match = (cmp_in == key_reg);
        mask  = (key_reg == correct_key);
        f     = match & ~mask;
    end

endmodule

// File: rtl/sarlock_seq_unlock.sv
// SARLock key unit: serial key load, key compare, 1-cycle protected output stage.
// Optional flip counter output enabled by defining SARLOCK_FLIP_CNT_EN.
module sarlock_seq_unlock
    import sarlock_pkg::*;
#(
    parameter int               KEY_W       = 8,
    parameter int               OUT_W       = 1,
    parameter logic [KEY_W-1:0] CORRECT_KEY = KEY_W'(DEFAULT_CORRECT_KEY),
    parameter logic [OUT_W-1:0] FLIP_SEL    = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    input  logic             key_reload,
    output logic             armed,
    input  logic [KEY_W-1:0] cmp_in,
    input  logic             data_valid,
    input  logic [OUT_W-1:0] data_in,
    output logic             data_out_valid,
    output logic [OUT_W-1:0] data_out,
    output logic             flip
`ifdef SARLOCK_FLIP_CNT_EN
    ,
    output logic [FLIP_CNT_W-1:0] flip_cnt
`endif
);

    localparam int             CNT_W    = cnt_width(KEY_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);

    state_t           state;
    logic [KEY_W-1:0] key_reg;
    logic [CNT_W-1:0] cnt;

    logic match;
    logic mask;
    logic f;
    logic take;
    logic unused_cmp;

    sarlock_key_cmp #(
        .KEY_W(KEY_W)
    ) u_key_cmp (
        .key_reg    (key_reg),
        .cmp_in     (cmp_in),
        .correct_key(CORRECT_KEY),
        .match      (match),
        .mask       (mask),
        .f          (f)
    );

    assign unused_cmp = ^{match, mask};

    // A reload cycle never produces a result, even if data arrives with it.
    assign take = data_valid & armed & ~key_reload;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_LOAD;
            key_reg        <= '0;
            cnt            <= '0;
            key_ready      <= 1'b1;
            armed          <= 1'b0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            flip           <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (key_reload) begin
                        key_reg <= '0;
                        cnt     <= '0;
                    end else if (key_valid && key_ready) begin
                        key_reg[cnt] <= key_bit;
                        if (cnt == LAST_BIT) begin
                            state     <= ST_ARMED;
                            cnt       <= '0;
                            key_ready <= 1'b0;
                            armed     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (key_reload) begin
                        state     <= ST_LOAD;
                        key_reg   <= '0;
                        cnt       <= '0;
                        key_ready <= 1'b1;
                        armed     <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_LOAD;
                    key_reg   <= '0;
                    cnt       <= '0;
                    key_ready <= 1'b1;
                    armed     <= 1'b0;
                end
            endcase

            data_out_valid <= take;
            if (take) begin
                data_out <= data_in ^ ({OUT_W{f}} & FLIP_SEL);
                flip     <= f;
            end
        end
    end

`ifdef SARLOCK_FLIP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || key_reload) begin
            flip_cnt <= '0;
        end else if (take && f && (flip_cnt != {FLIP_CNT_W{1'b1}})) begin
            flip_cnt <= flip_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sarlock_seq_unlock.sv
// Directed testbench for sarlock_seq_unlock: an 8-bit/1-output unit and a 4-output unit side by side.
module tb_sarlock_seq_unlock;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic       key_bit;
    logic       key_reload;
    logic [7:0] cmp_in;
    logic       data_valid;
    logic [0:0] data_in;
    logic [3:0] data_in4;

    logic       key_ready, armed, data_out_valid, flip;
    logic [0:0] data_out;
    logic       key_ready4, armed4, data_out_valid4, flip4;
    logic [3:0] data_out4;
`ifdef SARLOCK_FLIP_CNT_EN
    logic [15:0] flip_cnt, flip_cnt4;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] cmp;
        logic       din;
        logic       dv;
        logic       exp_dov;
        logic       exp_out;
        logic       exp_flip;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    sarlock_seq_unlock dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_bit       (key_bit),
        .key_ready     (key_ready),
        .key_reload    (key_reload),
        .armed         (armed),
        .cmp_in        (cmp_in),
        .data_valid    (data_valid),
        .data_in       (data_in),
        .data_out_valid(data_out_valid),
        .data_out      (data_out),
        .flip          (flip)
`ifdef SARLOCK_FLIP_CNT_EN
        ,
        .flip_cnt      (flip_cnt)
`endif
    );

    sarlock_seq_unlock #(
        .OUT_W   (4),
        .FLIP_SEL(4'b0101)
    ) dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_bit       (key_bit),
        .key_ready     (key_ready4),
        .key_reload    (key_reload),
        .armed         (armed4),
        .cmp_in        (cmp_in),
        .data_valid    (data_valid),
        .data_in       (data_in4),
        .data_out_valid(data_out_valid4),
        .data_out      (data_out4),
        .flip          (flip4)
`ifdef SARLOCK_FLIP_CNT_EN
        ,
        .flip_cnt      (flip_cnt4)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] c, input logic d, input logic [3:0] d4, input logic dv);
        cmp_in     = c;
        data_in    = d;
        data_in4   = d4;
        data_valid = dv;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic shift_bit(input logic b);
        key_valid = 1'b1;
        key_bit   = b;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] k);
        for (int i = 0; i < 8; i++) shift_bit(k[i]);
    endtask

    task automatic pulse_reload;
        key_reload = 1'b1;
        tick();
        key_reload = 1'b0;
    endtask

    // Full cmp_in sweep; expected flip comes from the SARLock rule with correct key 8'h4D.
    task automatic sweep(input logic [7:0] key, input string tag);
        logic ef;
        for (int c = 0; c < 256; c++) begin
            apply_stimulus(8'(c), 1'b1, 4'hF, 1'b1);
            ef = (8'(c) == key) && (key != 8'h4D);
            check_output({tag, "_dov"}, data_out_valid, 1'b1);
            check_output({tag, "_out"}, data_out, ef ? 1'b0 : 1'b1);
            check_output({tag, "_flip"}, flip, ef);
            check_output({tag, "_out4"}, data_out4, ef ? 4'b1010 : 4'b1111);
        end
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key_bit = 1'b0; key_reload = 1'b0;
        cmp_in = 8'h00; data_valid = 1'b0; data_in = 1'b0; data_in4 = 4'h0;

        vecs[0] = '{8'h4C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h4D, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h4C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h4C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h4C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        tick();
        tick();
        check_output("rst_key_ready", key_ready, 1'b1);
        check_output("rst_armed", armed, 1'b0);
        check_output("rst_dov", data_out_valid, 1'b0);
        check_output("rst_out", data_out, 1'b0);
        check_output("rst_flip", flip, 1'b0);
        check_output("rst_out4", data_out4, 4'h0);
        rst_n = 1'b1;

        // Load the correct key; armed rises on the edge of the 8th bit.
        for (int i = 0; i < 7; i++) shift_bit(bit'((8'h4D >> i) & 8'h01));
        check_output("load7_armed", armed, 1'b0);
        check_output("load7_ready", key_ready, 1'b1);
        shift_bit(1'b0);
        check_output("load8_armed", armed, 1'b1);
        check_output("load8_ready", key_ready, 1'b0);
        sweep(8'h4D, "good");
        tick();
        check_output("idle_dov", data_out_valid, 1'b0);

        // Wrong key 8'h4C: table vectors, then full sweep.
        pulse_reload();
        load_key(8'h4C);
        check_output("k4c_armed", armed, 1'b1);
        for (int v = 0; v < 7; v++) begin
            apply_stimulus(vecs[v].cmp, vecs[v].din, 4'h0, vecs[v].dv);
            check_output("vec_dov", data_out_valid, vecs[v].exp_dov);
            check_output("vec_out", data_out, vecs[v].exp_out);
            check_output("vec_flip", flip, vecs[v].exp_flip);
        end
        sweep(8'h4C, "k4c");

        // Multi-output flip select with wrong key 8'h00.
        pulse_reload();
        load_key(8'h00);
        apply_stimulus(8'h00, 1'b1, 4'b1111, 1'b1);
        check_output("mo_out4", data_out4, 4'b1010);
        check_output("mo_flip4", flip4, 1'b1);
        check_output("mo_out", data_out, 1'b0);
        apply_stimulus(8'h01, 1'b1, 4'b1111, 1'b1);
        check_output("mo_nomatch_out4", data_out4, 4'b1111);

        // Reload alongside valid data flushes the output stage.
        pulse_reload();
        load_key(8'h4D);
        apply_stimulus(8'h4D, 1'b1, 4'h0, 1'b1);
        check_output("pre_reload_dov", data_out_valid, 1'b1);
        cmp_in = 8'h4D; data_in = 1'b1; data_valid = 1'b1; key_reload = 1'b1;
        tick();
        key_reload = 1'b0; data_valid = 1'b0;
        check_output("reload_dov", data_out_valid, 1'b0);
        check_output("reload_armed", armed, 1'b0);
        check_output("reload_ready", key_ready, 1'b1);
        load_key(8'hFF);
        apply_stimulus(8'hFF, 1'b1, 4'h0, 1'b1);
        check_output("kff_flip", flip, 1'b1);
        check_output("kff_out", data_out, 1'b0);

        // Reload in LOAD beats a simultaneous key bit and restarts at bit 0.
        pulse_reload();
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        key_valid = 1'b1; key_bit = 1'b1; key_reload = 1'b1;
        tick();
        key_valid = 1'b0; key_reload = 1'b0;
        for (int i = 0; i < 7; i++) shift_bit(bit'((8'h4C >> i) & 8'h01));
        check_output("rl_load7_armed", armed, 1'b0);
        shift_bit(1'b0);
        check_output("rl_load8_armed", armed, 1'b1);
        apply_stimulus(8'h4C, 1'b1, 4'h0, 1'b1);
        check_output("rl_k4c_flip", flip, 1'b1);
        apply_stimulus(8'hCC, 1'b1, 4'h0, 1'b1);
        check_output("rl_kcc_flip", flip, 1'b0);

        // Reset mid-load, data before armed, and key_valid gaps.
        pulse_reload();
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_output("mid_rst_ready", key_ready, 1'b1);
        check_output("mid_rst_armed", armed, 1'b0);
        data_valid = 1'b1; cmp_in = 8'h4D; data_in = 1'b1;
        for (int i = 0; i < 7; i++) shift_bit(bit'((8'h4D >> i) & 8'h01));
        check_output("prearm_dov", data_out_valid, 1'b0);
        check_output("gap7_armed", armed, 1'b0);
        data_valid = 1'b0;
        tick();
        tick();
        check_output("gap_armed", armed, 1'b0);
        shift_bit(1'b0);
        check_output("gap8_armed", armed, 1'b1);
        shift_bit(1'b1);
        apply_stimulus(8'h4D, 1'b1, 4'h0, 1'b1);
        check_output("armed_ignore_flip", flip, 1'b0);
        check_output("armed_ignore_out", data_out, 1'b1);

`ifdef SARLOCK_FLIP_CNT_EN
        pulse_reload();
        check_output("fc_reload", flip_cnt, 16'd0);
        load_key(8'h4C);
        for (int i = 0; i < 5; i++) apply_stimulus(8'h4C, 1'b1, 4'h0, 1'b1);
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b1);
        apply_stimulus(8'h4C, 1'b1, 4'h0, 1'b0);
        check_output("fc_five", flip_cnt, 16'd5);
        pulse_reload();
        check_output("fc_cleared", flip_cnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sarlock_seq_unlock.md
Name: sarlock_seq_unlock

Overview:
- Parametrised, clocked SARLock key unit.
- Key arrives serially over a valid/ready handshake and is held in a register.
- Protected outputs pass through a 1-cycle pipeline. A bit is flipped when the compared input slice equals the loaded key and the loaded key is not the correct key.
- Sits between an obfuscated combinational core and its output pins. Generalises the fixed 8-bit, single-output flip/mask scheme to N key bits and M outputs, with reload support.

Parameters:
- KEY_W, 8: key width and width of the compared input slice.
- OUT_W, 1: number of protected output bits.
- CORRECT_KEY, 8'h4D: correct key value (bit i is key bit i); width KEY_W.
- FLIP_SEL, all ones: per-output enable of the flip; width OUT_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- key_valid  in  1  serial key bit valid.
- key_bit  in  1  serial key bit, LSB first.
- key_ready  out  1  unit accepts key bits.
- key_reload  in  1  pulse: discard the key and restart loading.
- armed  out  1  key fully loaded; datapath live.
- cmp_in  in  KEY_W  primary-input slice compared against the key.
- data_valid  in  1  data_in valid.
- data_in  in  OUT_W  raw (encrypted) core outputs.
- data_out_valid  out  1  data_out valid.
- data_out  out  OUT_W  protected outputs.
- flip  out  1  registered flip term, for debug.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears everything:
  - state=LOAD, key_reg=0, bit counter=0.
  - key_ready=1, armed=0, data_out_valid=0, data_out=0, flip=0.
- FSM has two states.
- LOAD state:
  - key_ready=1.
  - On key_valid&&key_ready: key_reg[cnt] <= key_bit, cnt++.
  - When the accepted bit has cnt==KEY_W-1: go to ARMED, cnt <= 0.
  - key_valid while not ready is ignored.
- ARMED state:
  - key_ready=0, armed=1.
  - key_reload=1 → go to LOAD and clear key_reg/cnt. The register stage is flushed: data_out_valid <= 0 on that edge.
  - key_reload in LOAD restarts the count at 0; key_reg is cleared.
  - key_reload wins over a simultaneous key bit.
- Flip logic (combinational, evaluated in ARMED):
  - match = (cmp_in == key_reg).
  - mask = (key_reg == CORRECT_KEY).
  - f = match & ~mask.
- Pipeline register, latency exactly 1 cycle:
  - data_out_valid <= data_valid & armed & ~key_reload.
  - When that term is 1: data_out <= data_in ^ ({OUT_W{f}} & FLIP_SEL), and flip <= f.
  - Otherwise data_out and flip hold their values.
- Inputs presented with data_valid while not armed are dropped, with no output.
- No back-pressure on the datapath: one result per valid input.
- Correct key loaded: data_out == data_in for every cmp_in.
- Wrong key K: exactly one cmp_in value (cmp_in==K) corrupts the FLIP_SEL bits.
- Reset mid-load or mid-stream discards all partial state. Loading resumes from bit 0.

Optional Feature:
- Macro SARLOCK_FLIP_CNT_EN.
- Defined: adds output flip_cnt (16 bits), cleared by reset and by key_reload. It increments on every valid output cycle with f=1 and saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package sarlock_pkg:
  - state enum {ST_LOAD, ST_ARMED}.
  - default CORRECT_KEY constant.
  - FLIP_CNT_W=16.
- Sub-module sarlock_key_cmp: purely combinational. Takes key_reg, cmp_in and CORRECT_KEY; produces match, mask, f. Parametrised by KEY_W.
- FSM, counter and pipeline register stay in the top module.

Test Plan:
- Load: reset; shift 8 bits of 8'h4D LSB first with key_valid=1 → key_ready drops and armed=1 on the edge after the 8th bit. Then, with data_in=1, sweep all 256 cmp_in → data_out==1 every cycle, flip=0, 1-cycle latency.
- Wrong key 8'h4C, OUT_W=1 → only cmp_in=8'h4C gives data_out=~data_in and flip=1. All 255 other values pass unchanged.
- Multi-output (OUT_W=4, FLIP_SEL=4'b0101): wrong key 8'h00, cmp_in=0, data_in=4'b1111 → data_out=4'b1010.
- Reload: armed with 8'h4D, assert key_reload together with data_valid → no output that cycle, armed=0, key_ready=1. Reload 8'hFF, then cmp_in=8'hFF → flip=1.
- Reset and handshake:
  - rst_n=0 after 3 key bits, then 8 new bits of 8'h4D → armed only after the full 8 new bits.
  - key_valid gaps stall the count.
  - data_valid before armed → data_out_valid stays 0.
- With SARLOCK_FLIP_CNT_EN: wrong key, 5 matching valid inputs → flip_cnt=5. key_reload → flip_cnt=0.
